// File: rtl/sinus_pkg.sv
// sinus_pkg: shared constants, quadrant type and helper functions for the
// quarter-wave sinus arbiter.
//   PHASE_W  : full-circle phase width ([9:8] quadrant, [7:0] angle)
//   QW_W     : quarter-wave ROM address / magnitude width
//   SAMPLE_W : signed full-wave sample width
package sinus_pkg;

    localparam int unsigned PHASE_W  = 10;
    localparam int unsigned QW_W     = 8;
    localparam int unsigned SAMPLE_W = 9;

    typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quadrant_e;

    // Map a full-circle phase onto the quarter-wave ROM address.
    function automatic logic [QW_W-1:0] fold_addr(input logic [PHASE_W-1:0] phase);
        quadrant_e       q;
        logic [QW_W-1:0] a;
        q = quadrant_e'(phase[PHASE_W-1:PHASE_W-2]);
        a = phase[QW_W-1:0];
        case (q)
            Q1, Q3:  fold_addr = ~a;  // 255 - a
            default: fold_addr = a;
        endcase
    endfunction

    // Lower half of the circle (Q2, Q3) yields a negative sample.
    function automatic logic phase_neg(input logic [PHASE_W-1:0] phase);
        quadrant_e q;
        q = quadrant_e'(phase[PHASE_W-1:PHASE_W-2]);
        phase_neg = (q == Q2) || (q == Q3);
    endfunction

    function automatic logic [SAMPLE_W-1:0] apply_sign(input logic neg,
                                                        input logic [QW_W-1:0] mag);
        logic [SAMPLE_W-1:0] ext;
        ext = {1'b0, mag};
        apply_sign = neg ? -ext : ext;
    endfunction

endpackage

// File: rtl/sinus_rr_arb.sv
// sinus_rr_arb: round-robin arbiter. Priority starts one past the last
// granted requester; the pointer moves only when the grant is taken.
//   clk, rst_n : clock, synchronous active-low reset
//   req        : request per requester
//   advance    : grant was accepted this cycle, update pointer
//   grant      : one-hot grant (combinational)
//   grant_id   : index of the granted requester
module sinus_rr_arb #(
    parameter int unsigned NREQ = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic                    advance,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_id
);

    localparam int unsigned ID_W = $clog2(NREQ);

    logic [ID_W-1:0] last_q;

    always_comb begin
        int unsigned idx;
        logic        found;
        idx      = 0;
        found    = 1'b0;
        grant    = '0;
        grant_id = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            idx = (32'(last_q) + off) % NREQ;
            if (!found && req[ID_W'(idx)]) begin
                found              = 1'b1;
                grant[ID_W'(idx)]  = 1'b1;
                grant_id           = ID_W'(idx);
            end
        end
    end

    // Reset to NREQ-1 so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= ID_W'(NREQ - 1);
        end else if (advance) begin
            last_q <= grant_id;
        end
    end

endmodule

// File: rtl/sinus_arbiter.sv
// sinus_arbiter: shares one registered quarter-wave sinus ROM among NREQ
// requesters, folds each full-circle phase to a ROM address and returns a
// signed full-wave sample tagged with the requester id, in grant order.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : grant enable (in-flight ops always drain)
//   req_valid  : request valid per requester
//   req_phase  : packed phases, requester i at [i*PHASE_W +: PHASE_W]
//   req_ready  : one-hot grant
//   rom_angle  : registered ROM address
//   rom_sinus  : ROM data, ROM_LAT cycles after rom_angle
//   rsp_valid  : one-cycle response strobe
//   rsp_id     : requester index of the response
//   rsp_sinus  : signed sample, -255..+255
//   busy       : any op in flight
module sinus_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned PHASE_W = 10,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*PHASE_W-1:0] req_phase,
    output logic [NREQ-1:0]         req_ready,
    output logic [7:0]              rom_angle,
    input  logic [7:0]              rom_sinus,
    output logic                    rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [8:0]              rsp_sinus,
    output logic                    busy
);

    import sinus_pkg::*;

    localparam int unsigned ID_W  = $clog2(NREQ);
    localparam int unsigned DEPTH = ROM_LAT + 1;

    logic [NREQ-1:0]    grant;
    logic [ID_W-1:0]    grant_id;
    logic               accept;
    logic [PHASE_W-1:0] sel_phase;

    // id/sign travel alongside the ROM access so the response lines up with rom_sinus
    logic               stage_valid [DEPTH];
    logic [ID_W-1:0]    stage_id    [DEPTH];
    logic               stage_neg   [DEPTH];

    sinus_rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req_valid),
        .advance  (accept),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // Grant only goes to valid requesters, so any ready bit is an accept.
    assign req_ready = grant & {NREQ{en & rst_n}};
    assign accept    = |req_ready;

    always_comb begin
        sel_phase = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant[i]) begin
                sel_phase = req_phase[i*PHASE_W +: PHASE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rom_angle <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sinus <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                stage_valid[k] <= 1'b0;
                stage_id[k]    <= '0;
                stage_neg[k]   <= 1'b0;
            end
        end else begin
            if (accept) begin
                rom_angle    <= fold_addr(sel_phase);
                stage_id[0]  <= grant_id;
                stage_neg[0] <= phase_neg(sel_phase);
            end
            stage_valid[0] <= accept;
            for (int k = 1; k < int'(DEPTH); k++) begin
                stage_valid[k] <= stage_valid[k-1];
                stage_id[k]    <= stage_id[k-1];
                stage_neg[k]   <= stage_neg[k-1];
            end
            rsp_valid <= stage_valid[DEPTH-1];
            if (stage_valid[DEPTH-1]) begin
                rsp_id    <= stage_id[DEPTH-1];
                rsp_sinus <= apply_sign(stage_neg[DEPTH-1], rom_sinus);
            end
        end
    end

    always_comb begin
        busy = rsp_valid;
        for (int k = 0; k < int'(DEPTH); k++) begin
            busy = busy | stage_valid[k];
        end
    end

endmodule

// File: tb/tb_sinus_arbiter.sv
module tb_sinus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [3:0]  req_valid;
    logic [39:0] req_phase;
    logic [3:0]  req_ready;
    logic [7:0]  rom_angle;
    logic [7:0]  rom_sinus;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [8:0]  rsp_sinus;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sinus_arbiter #(
        .NREQ    (4),
        .PHASE_W (10),
        .ROM_LAT (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_phase (req_phase),
        .req_ready (req_ready),
        .rom_angle (rom_angle),
        .rom_sinus (rom_sinus),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sinus (rsp_sinus),
        .busy      (busy)
    );

    // ROM stand-in: round(255*sin(a*pi/510)) at the angles used here.
    function automatic logic [7:0] rom_f(input logic [7:0] a);
        case (a)
            8'd64:   return 8'd98;
            8'd191:  return 8'd235;
            8'd255:  return 8'd255;
            default: return a;
        endcase
    endfunction

    always @(posedge clk) rom_sinus <= rom_f(rom_angle);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        en        = 1'b1;
        req_valid = 4'hF;
        req_phase = {10'h340, 10'h240, 10'h140, 10'h040};
        step();
        step();
        #1;
        n_checks++; if (req_ready !== 4'h0) begin n_fail++;
            $display("FAIL reset_ready got=%h want=0", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        n_checks++; if (rom_angle !== 8'd0) begin n_fail++;
            $display("FAIL reset_rom_angle got=%0d want=0", rom_angle); end
        n_checks++; if (busy !== 1'b0) begin n_fail++;
            $display("FAIL reset_busy got=%b want=0", busy); end
        n_checks++; if (rsp_sinus !== 9'd0 || rsp_id !== 2'd0) begin n_fail++;
            $display("FAIL reset_rsp got=%h/%0d want=0/0", rsp_sinus, rsp_id); end
        req_valid = 4'h0;
        rst_n     = 1'b1;
        step();
    endtask

    task automatic test_single();
        req_phase[9:0] = 10'h040;
        req_valid      = 4'h1;
        #1;
        n_checks++; if (req_ready !== 4'h1) begin n_fail++;
            $display("FAIL single_ready got=%h want=1", req_ready); end
        step();
        req_valid = 4'h0;
        #1;
        n_checks++; if (rom_angle !== 8'd64) begin n_fail++;
            $display("FAIL single_angle got=%0d want=64", rom_angle); end
        n_checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++;
            $display("FAIL single_t1 busy/rsp got=%b/%b want=1/0", busy, rsp_valid); end
        step();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++;
            $display("FAIL single_t2_rsp got=%b want=0", rsp_valid); end
        step();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sinus !== 9'd98)
            begin n_fail++;
            $display("FAIL single_rsp got v=%b id=%0d s=%h want 1/0/062",
                     rsp_valid, rsp_id, rsp_sinus); end
        n_checks++; if (busy !== 1'b1) begin n_fail++;
            $display("FAIL single_t3_busy got=%b want=1", busy); end
        step();
        n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_sinus !== 9'd98)
            begin n_fail++;
            $display("FAIL single_idle got v=%b b=%b s=%h want 0/0/062",
                     rsp_valid, busy, rsp_sinus); end
    endtask

    // Quadrants and fold edges, issued back-to-back from requester 0.
    task automatic test_fold();
        logic [9:0] ph  [7] = '{10'h140, 10'h240, 10'h340, 10'h000, 10'h0FF, 10'h100, 10'h300};
        logic [7:0] ang [7] = '{8'd191, 8'd64, 8'd191, 8'd0, 8'd255, 8'd255, 8'd255};
        logic [8:0] smp [7] = '{9'd235, 9'h19E, 9'h115, 9'd0, 9'd255, 9'd255, 9'h101};
        for (int k = 0; k < 10; k++) begin
            if (k < 7) begin
                req_valid      = 4'h1;
                req_phase[9:0] = ph[k];
            end else begin
                req_valid = 4'h0;
            end
            #1;
            if (k < 7) begin
                n_checks++; if (req_ready !== 4'h1) begin n_fail++;
                    $display("FAIL fold_ready k=%0d got=%h want=1", k, req_ready); end
            end
            if (k >= 1 && k <= 7) begin
                n_checks++; if (rom_angle !== ang[k-1]) begin n_fail++;
                    $display("FAIL fold_angle k=%0d got=%0d want=%0d", k, rom_angle, ang[k-1]);
                end
            end
            if (k >= 3) begin
                n_checks++; if (rsp_valid !== 1'b1 || rsp_sinus !== smp[k-3]) begin n_fail++;
                    $display("FAIL fold_rsp k=%0d got v=%b s=%h want 1/%h",
                             k, rsp_valid, rsp_sinus, smp[k-3]); end
            end
            step();
        end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++;
            $display("FAIL fold_end_rsp got=%b want=0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic [7:0] ang [4] = '{8'd64, 8'd191, 8'd64, 8'd191};
        logic [8:0] smp [4] = '{9'd98, 9'd235, 9'h19E, 9'h115};
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        req_phase = {10'h340, 10'h240, 10'h140, 10'h040};
        for (int k = 0; k < 11; k++) begin
            req_valid = (k < 8) ? 4'hF : 4'h0;
            #1;
            n_checks++;
            if (req_ready !== ((k < 8) ? 4'(1 << (k % 4)) : 4'h0)) begin n_fail++;
                $display("FAIL rr_grant k=%0d got=%h", k, req_ready); end
            if (k >= 1 && k <= 8) begin
                n_checks++; if (rom_angle !== ang[(k-1)%4]) begin n_fail++;
                    $display("FAIL rr_angle k=%0d got=%0d want=%0d",
                             k, rom_angle, ang[(k-1)%4]); end
            end
            if (k >= 3) begin
                n_checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'((k-3) % 4) ||
                    rsp_sinus !== smp[(k-3)%4]) begin n_fail++;
                    $display("FAIL rr_rsp k=%0d got v=%b id=%0d s=%h want 1/%0d/%h",
                             k, rsp_valid, rsp_id, rsp_sinus, (k-3)%4, smp[(k-3)%4]); end
            end
            step();
        end
    endtask

    task automatic test_reset_midop_and_en();
        req_phase[9:0]   = 10'h040;
        req_phase[29:20] = 10'h240;
        for (int k = 0; k < 3; k++) begin
            req_valid = 4'h1;
            step();
        end
        req_valid = 4'h0;
        rst_n     = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++;
                $display("FAIL midrst_drop k=%0d got v=%b b=%b want 0/0", k, rsp_valid, busy);
            end
            step();
        end
        en        = 1'b0;
        req_valid = 4'h4;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (req_ready !== 4'h0 || rsp_valid !== 1'b0) begin n_fail++;
                $display("FAIL en_off k=%0d got r=%h v=%b want 0/0", k, req_ready, rsp_valid);
            end
            step();
        end
        en = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'h4) begin n_fail++;
            $display("FAIL en_on_ready got=%h want=4", req_ready); end
        step();
        req_valid = 4'h0;
        #1;
        n_checks++; if (rom_angle !== 8'd64) begin n_fail++;
            $display("FAIL en_on_angle got=%0d want=64", rom_angle); end
        step();
        step();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sinus !== 9'h19E)
            begin n_fail++;
            $display("FAIL en_on_rsp got v=%b id=%0d s=%h want 1/2/19e",
                     rsp_valid, rsp_id, rsp_sinus); end
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++;
            $display("FAIL en_on_busy got=%b want=0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fold();
        test_round_robin();
        test_reset_midop_and_en();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
